// File: rtl/CDB_types.sv
// Shared rename types and default sizes for the register alias table.
// Contents:
//   NUM_ARCH, NUM_PHYS      architectural / physical register counts
//   DISP_W, CDB_W, COMMIT_W rename, broadcast and commit port counts
//   ARCH_W, PHYS_W          register index widths
//   rename_slot_t           one rename request {valid, rs1, rs2, rd, pd}
package CDB_types;

    localparam int unsigned NUM_ARCH = 32;
    localparam int unsigned NUM_PHYS = 64;
    localparam int unsigned DISP_W   = 2;
    localparam int unsigned CDB_W    = 2;
    localparam int unsigned COMMIT_W = 2;

    localparam int unsigned ARCH_W = $clog2(NUM_ARCH);
    localparam int unsigned PHYS_W = $clog2(NUM_PHYS);

    typedef struct packed {
        logic              valid;
        logic [ARCH_W-1:0] rs1;
        logic [ARCH_W-1:0] rs2;
        logic [ARCH_W-1:0] rd;
        logic [PHYS_W-1:0] pd;
    } rename_slot_t;

endpackage

// File: rtl/rrat.sv
// Retirement register alias table: the committed arch->phys mapping.
// Ports:
//   clk, rst       clock, asynchronous active-high reset (identity map)
//   commit_valid   per-port retirement strobe, port 0 oldest
//   commit_rd      retiring architectural destination
//   commit_pd      physical register it now maps to
//   map            committed map including this cycle's commits, i.e. the
//                  value the table holds after the coming edge
module rrat #(
    parameter int unsigned NUM_ARCH = CDB_types::NUM_ARCH,
    parameter int unsigned NUM_PHYS = CDB_types::NUM_PHYS,
    parameter int unsigned COMMIT_W = CDB_types::COMMIT_W,
    localparam int unsigned AW = $clog2(NUM_ARCH),
    localparam int unsigned PW = $clog2(NUM_PHYS)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [COMMIT_W-1:0]                commit_valid,
    input  logic [COMMIT_W-1:0][AW-1:0]        commit_rd,
    input  logic [COMMIT_W-1:0][PW-1:0]        commit_pd,
    output logic [NUM_ARCH-1:0][PW-1:0]        map
);

    logic [NUM_ARCH-1:0][PW-1:0] rrat_q;

    // Ascending port order lets the youngest port win on a shared rd.
    always_comb begin
        map = rrat_q;
        for (int p = 0; p < COMMIT_W; p++) begin
            if (commit_valid[p] && commit_rd[p] != '0) begin
                map[commit_rd[p]] = commit_pd[p];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_ARCH; r++) begin
                rrat_q[r] <= PW'(r);
            end
        end else begin
            rrat_q <= map;
        end
    end

endmodule

// File: rtl/multi_port_rat.sv
// Multi-port speculative register alias table with CDB wakeup, retirement
// map and flush recovery.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   disp_valid, rs1, rs2, rd  per-slot rename requests, slot 0 oldest
//   pd                        new physical destination per slot
//   ps1, ps2, ps*_valid       renamed sources and readiness (combinational)
//   old_pd                    previous mapping of rd (combinational)
//   cdb_valid, cdb_pd         completion broadcasts
//   commit_valid/rd/pd        retirement updates into the RRAT
//   flush                     restore the speculative map from the RRAT
module multi_port_rat #(
    parameter int unsigned NUM_ARCH = CDB_types::NUM_ARCH,
    parameter int unsigned NUM_PHYS = CDB_types::NUM_PHYS,
    parameter int unsigned DISP_W   = CDB_types::DISP_W,
    parameter int unsigned CDB_W    = CDB_types::CDB_W,
    parameter int unsigned COMMIT_W = CDB_types::COMMIT_W,
    localparam int unsigned AW = $clog2(NUM_ARCH),
    localparam int unsigned PW = $clog2(NUM_PHYS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DISP_W-1:0]           disp_valid,
    input  logic [DISP_W-1:0][AW-1:0]   rs1,
    input  logic [DISP_W-1:0][AW-1:0]   rs2,
    input  logic [DISP_W-1:0][AW-1:0]   rd,
    input  logic [DISP_W-1:0][PW-1:0]   pd,
    output logic [DISP_W-1:0][PW-1:0]   ps1,
    output logic [DISP_W-1:0][PW-1:0]   ps2,
    output logic [DISP_W-1:0]           ps1_valid,
    output logic [DISP_W-1:0]           ps2_valid,
    output logic [DISP_W-1:0][PW-1:0]   old_pd,
    input  logic [CDB_W-1:0]            cdb_valid,
    input  logic [CDB_W-1:0][PW-1:0]    cdb_pd,
    input  logic [COMMIT_W-1:0]         commit_valid,
    input  logic [COMMIT_W-1:0][AW-1:0] commit_rd,
    input  logic [COMMIT_W-1:0][PW-1:0] commit_pd,
    input  logic                        flush
);

    logic [NUM_ARCH-1:0][PW-1:0] map_q, map_d, rrat_next;
    logic [NUM_ARCH-1:0]         rdy_q, rdy_d;

    function automatic logic cdb_match(input logic [PW-1:0]             p,
                                       input logic [CDB_W-1:0]          v,
                                       input logic [CDB_W-1:0][PW-1:0]  pds);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < CDB_W; k++) begin
            if (v[k] && pds[k] == p) hit = 1'b1;
        end
        return hit;
    endfunction

    rrat #(
        .NUM_ARCH (NUM_ARCH),
        .NUM_PHYS (NUM_PHYS),
        .COMMIT_W (COMMIT_W)
    ) u_rrat (
        .clk          (clk),
        .rst          (rst),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_pd    (commit_pd),
        .map          (rrat_next)
    );

    // Rename read: table (with CDB bypass), overridden by the youngest older
    // slot writing the same register, overridden by the x0 rule.
    always_comb begin
        ps1       = '0;
        ps2       = '0;
        ps1_valid = '0;
        ps2_valid = '0;
        old_pd    = '0;
        for (int i = 0; i < DISP_W; i++) begin
            ps1[i]       = map_q[rs1[i]];
            ps1_valid[i] = rdy_q[rs1[i]] | cdb_match(map_q[rs1[i]], cdb_valid, cdb_pd);
            ps2[i]       = map_q[rs2[i]];
            ps2_valid[i] = rdy_q[rs2[i]] | cdb_match(map_q[rs2[i]], cdb_valid, cdb_pd);
            old_pd[i]    = map_q[rd[i]];
            for (int j = 0; j < DISP_W; j++) begin
                if (j < i && disp_valid[j]) begin
                    if (rd[j] == rs1[i]) begin
                        ps1[i]       = pd[j];
                        ps1_valid[i] = 1'b0;
                    end
                    if (rd[j] == rs2[i]) begin
                        ps2[i]       = pd[j];
                        ps2_valid[i] = 1'b0;
                    end
                    if (rd[j] == rd[i]) old_pd[i] = pd[j];
                end
            end
            if (rs1[i] == '0) begin
                ps1[i]       = '0;
                ps1_valid[i] = 1'b1;
            end
            if (rs2[i] == '0) begin
                ps2[i]       = '0;
                ps2_valid[i] = 1'b1;
            end
            if (rd[i] == '0) old_pd[i] = '0;
        end
    end

    // Next state: CDB wakeup against the current map, then dispatch writes
    // (youngest slot last so it wins, and dispatch overrides the wakeup).
    always_comb begin
        map_d = map_q;
        rdy_d = rdy_q;
        for (int r = 0; r < NUM_ARCH; r++) begin
            if (cdb_match(map_q[r], cdb_valid, cdb_pd)) rdy_d[r] = 1'b1;
        end
        for (int i = 0; i < DISP_W; i++) begin
            if (disp_valid[i] && rd[i] != '0) begin
                map_d[rd[i]] = pd[i];
                rdy_d[rd[i]] = 1'b0;
            end
        end
        if (flush) begin
            map_d = rrat_next;
            rdy_d = '1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_ARCH; r++) begin
                map_q[r] <= PW'(r);
            end
            rdy_q <= '1;
        end else begin
            map_q <= map_d;
            rdy_q <= rdy_d;
        end
    end

endmodule

// File: tb/tb_multi_port_rat.sv
// Directed self-checking bench for multi_port_rat.
module tb_multi_port_rat;
    import CDB_types::*;

    localparam int unsigned AW = ARCH_W;
    localparam int unsigned PW = PHYS_W;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [DISP_W-1:0]           disp_valid;
    logic [DISP_W-1:0][AW-1:0]   rs1, rs2, rd;
    logic [DISP_W-1:0][PW-1:0]   pd, ps1, ps2, old_pd;
    logic [DISP_W-1:0]           ps1_valid, ps2_valid;
    logic [CDB_W-1:0]            cdb_valid;
    logic [CDB_W-1:0][PW-1:0]    cdb_pd;
    logic [COMMIT_W-1:0]         commit_valid;
    logic [COMMIT_W-1:0][AW-1:0] commit_rd;
    logic [COMMIT_W-1:0][PW-1:0] commit_pd;
    logic                        flush;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multi_port_rat dut (
        .clk          (clk),
        .rst          (rst),
        .disp_valid   (disp_valid),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd),
        .pd           (pd),
        .ps1          (ps1),
        .ps2          (ps2),
        .ps1_valid    (ps1_valid),
        .ps2_valid    (ps2_valid),
        .old_pd       (old_pd),
        .cdb_valid    (cdb_valid),
        .cdb_pd       (cdb_pd),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_pd    (commit_pd),
        .flush        (flush)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        disp_valid   = '0;
        rs1          = '0;
        rs2          = '0;
        rd           = '0;
        pd           = '0;
        cdb_valid    = '0;
        cdb_pd       = '0;
        commit_valid = '0;
        commit_rd    = '0;
        commit_pd    = '0;
        flush        = 1'b0;
    endtask

    task automatic set_slot(input int i, input logic v, input int a1, input int a2,
                            input int d, input int p);
        rename_slot_t s;
        s.valid       = v;
        s.rs1         = AW'(a1);
        s.rs2         = AW'(a2);
        s.rd          = AW'(d);
        s.pd          = PW'(p);
        disp_valid[i] = s.valid;
        rs1[i]        = s.rs1;
        rs2[i]        = s.rs2;
        rd[i]         = s.rd;
        pd[i]         = s.pd;
    endtask

    task automatic set_commit(input int k, input int d, input int p);
        commit_valid[k] = 1'b1;
        commit_rd[k]    = AW'(d);
        commit_pd[k]    = PW'(p);
    endtask

    task automatic set_cdb(input int k, input int p);
        cdb_valid[k] = 1'b1;
        cdb_pd[k]    = PW'(p);
    endtask

    // Begin a stimulus phase in the low half of the clock.
    task automatic start();
        @(negedge clk);
        idle();
    endtask

    // Apply the current stimulus on one rising edge, then go idle.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    // Read one table entry through slot 0 with no dispatch or CDB active.
    task automatic table_chk(input string tag, input int a, input int exp_pd, input int exp_v);
        start();
        rs1[0] = AW'(a);
        #1;
        check({tag, "_pd"}, 32'(ps1[0]), 32'(exp_pd));
        check({tag, "_v"}, 32'(ps1_valid[0]), 32'(exp_v));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset: identity outputs while rst is high
        idle();
        rst = 1'b1;
        rs1[0] = 5; rs2[0] = 6; rd[0] = 7; rs1[1] = 31;
        #1;
        check("rst_ps1", 32'(ps1[0]), 5);
        check("rst_ps2", 32'(ps2[0]), 6);
        check("rst_v", 32'({ps1_valid[0], ps2_valid[0]}), 3);
        check("rst_old", 32'(old_pd[0]), 7);
        check("rst_ps1_s1", 32'(ps1[1]), 31);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Plain lookup after reset
        start();
        rs1[0] = 5; rs2[0] = 6;
        #1;
        check("post_rst_ps1", 32'(ps1[0]), 5);
        check("post_rst_ps2", 32'(ps2[0]), 6);
        check("post_rst_v", 32'({ps1_valid[0], ps2_valid[0]}), 3);

        // Intra-group forwarding
        start();
        set_slot(0, 1, 3, 4, 1, 32);
        set_slot(1, 1, 1, 2, 10, 36);
        #1;
        check("fwd_ps1", 32'(ps1[1]), 32);
        check("fwd_v", 32'(ps1_valid[1]), 0);
        check("fwd_ps2", 32'(ps2[1]), 2);
        check("fwd_old0", 32'(old_pd[0]), 1);
        check("fwd_old1", 32'(old_pd[1]), 10);
        check("fwd_ps1_s0", 32'(ps1[0]), 3);
        tick();
        table_chk("tab_x1", 1, 32, 0);
        table_chk("tab_x10", 10, 36, 0);

        // CDB bypass on a table operand, then wakeup
        start();
        set_cdb(0, 32);
        rs1[0] = 1; rs2[0] = 10;
        #1;
        check("byp_ps1", 32'(ps1[0]), 32);
        check("byp_v1", 32'(ps1_valid[0]), 1);
        check("byp_v2", 32'(ps2_valid[0]), 0);
        tick();
        table_chk("wake_x1", 1, 32, 1);

        // No bypass on forwarded operand; dispatch beats CDB on the same entry
        start();
        set_slot(0, 1, 0, 0, 10, 38);
        set_slot(1, 1, 10, 0, 11, 39);
        set_cdb(0, 36);
        set_cdb(1, 38);
        #1;
        check("nobyp_ps1", 32'(ps1[1]), 38);
        check("nobyp_v", 32'(ps1_valid[1]), 0);
        check("nobyp_old0", 32'(old_pd[0]), 36);
        tick();
        table_chk("dwin_x10", 10, 38, 0);
        table_chk("dwin_x11", 11, 39, 0);

        // Two slots write the same rd
        start();
        set_slot(0, 1, 0, 0, 2, 33);
        set_slot(1, 1, 0, 0, 2, 34);
        #1;
        check("waw_old0", 32'(old_pd[0]), 2);
        check("waw_old1", 32'(old_pd[1]), 33);
        tick();
        table_chk("waw_x2", 2, 34, 0);

        // x0 is hardwired
        start();
        set_slot(0, 1, 0, 0, 0, 50);
        set_slot(1, 1, 0, 0, 0, 51);
        #1;
        check("x0_ps1", 32'(ps1[0]), 0);
        check("x0_v", 32'({ps1_valid[1], ps1_valid[0]}), 3);
        check("x0_ps1_s1", 32'(ps1[1]), 0);
        check("x0_old1", 32'(old_pd[1]), 0);
        tick();
        table_chk("x0_tab", 0, 0, 1);

        // Dispatch, commit, redispatch, flush
        start(); set_slot(0, 1, 0, 0, 3, 40); tick();
        start(); set_commit(0, 3, 40); tick();
        start(); set_slot(0, 1, 0, 0, 3, 41); tick();
        table_chk("spec_x3", 3, 41, 0);
        start(); flush = 1'b1; tick();
        table_chk("fl_x3", 3, 40, 1);
        table_chk("fl_x1", 1, 1, 1);
        table_chk("fl_x2", 2, 2, 1);
        table_chk("fl_x10", 10, 10, 1);

        // Flush with every port active; same-cycle commits included
        start();
        flush = 1'b1;
        set_commit(0, 4, 45);
        set_commit(1, 4, 46);
        set_slot(0, 1, 1, 2, 5, 50);
        set_slot(1, 1, 5, 3, 6, 51);
        set_cdb(0, 40);
        set_cdb(1, 50);
        tick();
        table_chk("flall_x4", 4, 46, 1);
        table_chk("flall_x5", 5, 5, 1);

        // Back-to-back flushes
        start(); flush = 1'b1; set_commit(0, 6, 47); set_commit(1, 0, 52);
        @(posedge clk); #1;
        idle(); flush = 1'b1; set_commit(1, 7, 48); set_slot(0, 1, 0, 0, 6, 53);
        tick();
        table_chk("b2b_x6", 6, 47, 1);
        table_chk("b2b_x7", 7, 48, 1);
        table_chk("b2b_x4", 4, 46, 1);
        table_chk("b2b_x0", 0, 0, 1);

        // Reset mid-stream with everything active
        start(); set_slot(0, 1, 0, 0, 8, 54); tick();
        table_chk("pre_rst_x8", 8, 54, 0);
        start();
        set_slot(0, 1, 8, 4, 8, 55);
        set_slot(1, 1, 0, 0, 9, 56);
        set_cdb(0, 60);
        set_cdb(1, 61);
        set_commit(0, 9, 57);
        set_commit(1, 4, 58);
        flush = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        check("mrst_ps1", 32'(ps1[0]), 8);
        check("mrst_ps2", 32'(ps2[0]), 4);
        check("mrst_v", 32'({ps1_valid[0], ps2_valid[0]}), 3);
        check("mrst_old", 32'(old_pd[0]), 8);
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        rst = 1'b0;
        table_chk("mrst_x9", 9, 9, 1);
        table_chk("mrst_x7", 7, 7, 1);
        start(); flush = 1'b1; tick();
        table_chk("mrst_rrat_x4", 4, 4, 1);
        table_chk("mrst_rrat_x6", 6, 6, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
